vga_text_writer: RTL

//  Write side of the VGA character buffer. Accepts ASCII characters over a valid/ready

---
 rtl/vga_text_writer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/vga_text_writer.sv
// vga_text_writer: write side of the VGA text buffer.
// Accepts ASCII over valid/ready, tracks a text cursor, and writes characters
// into a 32-bit-word video RAM at byte address {row[4:0], col[6:0]}.
// Handles LF/CR/BS/FF control codes, line wrap with row blanking, and full clears.
// Optional: define TEXT_CLEAR_ON_RESET_EN to blank the whole screen after reset release.
module vga_text_writer #(
  parameter int ROWS = 30,
  parameter int COLS = 70
) (
  input  logic        CLOCK_50,
  input  logic        clrn,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic        wr_en,
  output logic [9:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_byte_en,
  output logic [4:0]  cursor_row,
  output logic [6:0]  cursor_col,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, PUT, CLR_ROW, CLR_ALL} state_t;

  localparam logic [4:0]  ROW_LAST = 5'(ROWS - 1);
  localparam logic [6:0]  COL_LAST = 7'(COLS - 1);
  localparam logic [9:0]  CLR_LAST = 10'(ROWS * 32 - 1);
  localparam logic [31:0] BLANK    = 32'h20202020;

  state_t      state_q, state_d;
  logic        started_q, started_d;
  logic [7:0]  char_q, char_d;
  logic [4:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic [9:0]  clr_cnt_q, clr_cnt_d;
  logic [9:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        advance;

  // State, cursor, clear counter and held write bus registers
  always_ff @(posedge CLOCK_50 or negedge clrn) begin
    if (!clrn) begin
      state_q   <= IDLE;
      started_q <= 1'b0;
      char_q    <= 8'h00;
      row_q     <= 5'd0;
      col_q     <= 7'd0;
      clr_cnt_q <= 10'd0;
      wr_addr_q <= 10'd0;
      wr_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      started_q <= started_d;
      char_q    <= char_d;
      row_q     <= row_d;
      col_q     <= col_d;
      clr_cnt_q <= clr_cnt_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Next-state, cursor update and RAM write generation
  always_comb begin
    state_d    = state_q;
    started_d  = 1'b1;
    char_d     = char_q;
    row_d      = row_q;
    col_d      = col_q;
    clr_cnt_d  = clr_cnt_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_en      = 1'b0;
    wr_byte_en = 4'b0000;
    char_ready = 1'b0;
    busy       = 1'b0;
    advance    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!started_q) begin
`ifdef TEXT_CLEAR_ON_RESET_EN
          state_d   = CLR_ALL;
          clr_cnt_d = 10'd0;
`else
          state_d   = IDLE;
`endif
        end else begin
          char_ready = 1'b1;
          if (char_valid) begin
            char_d  = char_in;
            state_d = PUT;
          end
        end
      end

      PUT: begin
        state_d = IDLE;
        if (char_q >= 8'h20 && char_q <= 8'h7E) begin
          wr_en      = 1'b1;
          wr_addr_d  = {row_q, col_q[6:2]};
          wr_data_d  = {4{char_q}};
          wr_byte_en = 4'b0001 << col_q[1:0];
          if (col_q == COL_LAST) begin
            col_d   = 7'd0;
            advance = 1'b1;
          end else begin
            col_d = col_q + 7'd1;
          end
        end else begin
          case (char_q)
            8'h0A: begin
              col_d   = 7'd0;
              advance = 1'b1;
            end
            8'h0D: col_d = 7'd0;
            8'h08: begin
              if (col_q != 7'd0) begin
                col_d      = col_q - 7'd1;
                wr_en      = 1'b1;
                wr_addr_d  = {row_q, col_d[6:2]};
                wr_data_d  = BLANK;
                wr_byte_en = 4'b0001 << col_d[1:0];
              end else if (row_q != 5'd0) begin
                row_d      = row_q - 5'd1;
                col_d      = COL_LAST;
                wr_en      = 1'b1;
                wr_addr_d  = {row_d, col_d[6:2]};
                wr_data_d  = BLANK;
                wr_byte_en = 4'b0001 << col_d[1:0];
              end
            end
            8'h0C: begin
              row_d     = 5'd0;
              col_d     = 7'd0;
              clr_cnt_d = 10'd0;
              state_d   = CLR_ALL;
            end
            default: ;
          endcase
        end
        if (advance) begin
          if (row_q == ROW_LAST) begin
            row_d     = 5'd0;
            clr_cnt_d = 10'd0;
            state_d   = CLR_ROW;
          end else begin
            row_d = row_q + 5'd1;
          end
        end
      end

      CLR_ROW: begin
        busy       = 1'b1;
        wr_en      = 1'b1;
        wr_addr_d  = {row_q, clr_cnt_q[4:0]};
        wr_data_d  = BLANK;
        wr_byte_en = 4'hF;
        if (clr_cnt_q[4:0] == 5'd31) begin
          clr_cnt_d = 10'd0;
          state_d   = IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 10'd1;
        end
      end

      CLR_ALL: begin
        busy       = 1'b1;
        wr_en      = 1'b1;
        wr_addr_d  = clr_cnt_q;
        wr_data_d  = BLANK;
        wr_byte_en = 4'hF;
        if (clr_cnt_q == CLR_LAST) begin
          clr_cnt_d = 10'd0;
          state_d   = IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 10'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign wr_addr    = wr_addr_d;
  assign wr_data    = wr_data_d;
  assign cursor_row = row_q;
  assign cursor_col = col_q;

endmodule
